// File: rtl/meas_scan_mux.sv
// Registered measurement channel selector: a manual single-channel capture or an ascending
// scan over a channel range, with a programmable settle delay and a valid/ready output.
module meas_scan_mux #(
  parameter int C_INUM    = 48,
  parameter int C_IDWIDTH = 24,
  parameter int C_ISWIDTH = 6,
  parameter int C_SETTLE  = 2
) (
  input  logic                           I_clk,
  input  logic                           I_rst_n,
  input  logic [C_INUM*C_IDWIDTH-1:0]    I_data,
  input  logic                           I_mode,
  input  logic [C_ISWIDTH-1:0]           I_sel,
  input  logic [C_ISWIDTH-1:0]           I_first,
  input  logic [C_ISWIDTH-1:0]           I_last,
  input  logic                           I_start,
  input  logic                           I_abort,
  input  logic                           I_ready,
  output logic [C_IDWIDTH-1:0]           O_data,
  output logic [C_ISWIDTH-1:0]           O_ch,
  output logic                           O_valid,
  output logic                           O_busy,
  output logic                           O_done,
  output logic                           O_err
);

  localparam int CW = (C_SETTLE > 0) ? $clog2(C_SETTLE + 1) : 1;
  localparam logic [C_ISWIDTH:0] NUM_CH = (C_ISWIDTH + 1)'(C_INUM);
  localparam logic [CW-1:0] SETTLE_LOAD = CW'(C_SETTLE);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETTLE,
    S_HOLD,
    S_DONE
  } state_t;

  state_t                 state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [C_ISWIDTH-1:0]   curCh_q, curCh_d;
  logic [C_ISWIDTH-1:0]   endCh_q, endCh_d;
  logic [C_IDWIDTH-1:0]   data_q, data_d;
  logic [C_ISWIDTH-1:0]   ch_q, ch_d;
  logic                   valid_q, valid_d;
  logic                   err_q, err_d;

  logic [C_IDWIDTH-1:0]   chans [C_INUM];
  logic [C_ISWIDTH-1:0]   startCur, startEnd;
  logic                   startBad;

  for (genvar n = 0; n < C_INUM; n++) begin : g_chan
    assign chans[n] = I_data[n*C_IDWIDTH +: C_IDWIDTH];
  end

  // A start is rejected if either bound lies outside the channel bank or a scan range is inverted.
  always_comb begin
    startCur = I_mode ? I_first : I_sel;
    startEnd = I_mode ? I_last  : I_sel;
    startBad = ({1'b0, startCur} >= NUM_CH) || ({1'b0, startEnd} >= NUM_CH) ||
               (I_mode && (I_first > I_last));
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    curCh_d = curCh_q;
    endCh_d = endCh_q;
    data_d  = data_q;
    ch_d    = ch_q;
    valid_d = valid_q;
    err_d   = 1'b0;

    if (I_abort) begin
      state_d = S_IDLE;
      valid_d = 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (I_start) begin
            if (startBad) begin
              err_d = 1'b1;
            end else begin
              curCh_d = startCur;
              endCh_d = startEnd;
              cnt_d   = SETTLE_LOAD;
              state_d = S_SETTLE;
            end
          end
        end
        S_SETTLE: begin
          if (cnt_q != '0) begin
            cnt_d = cnt_q - CW'(1);
          end else begin
            data_d  = chans[curCh_q];
            ch_d    = curCh_q;
            valid_d = 1'b1;
            state_d = S_HOLD;
          end
        end
        // Output words stay frozen until the reader takes them.
        S_HOLD: begin
          if (I_ready) begin
            valid_d = 1'b0;
            if (curCh_q == endCh_q) begin
              state_d = S_DONE;
            end else begin
              curCh_d = curCh_q + C_ISWIDTH'(1);
              cnt_d   = SETTLE_LOAD;
              state_d = S_SETTLE;
            end
          end
        end
        S_DONE: begin
          state_d = S_IDLE;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      curCh_q <= '0;
      endCh_q <= '0;
      data_q  <= '0;
      ch_q    <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      curCh_q <= curCh_d;
      endCh_q <= endCh_d;
      data_q  <= data_d;
      ch_q    <= ch_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  assign O_data  = data_q;
  assign O_ch    = ch_q;
  assign O_valid = valid_q;
  assign O_busy  = (state_q != S_IDLE);
  assign O_done  = (state_q == S_DONE);
  assign O_err   = err_q;

endmodule
